// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the ID-stage hazard detection logic.
//   - hdu_state_t : hazard FSM state encoding (IDLE / STALL)
//   - REG_ADDR_W  : register address width
//   - REG_ZERO    : hard-wired zero register address
//   - ID/EX control-field bit positions (MemRead lives in the mem field)
package cpu_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_STALL = 1'b1
   } hdu_state_t;

   localparam int REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // ID/EX control bundle: {wb[1:0], mem[2:0], ex[3:0]}
   localparam int IDEX_EX_W        = 4;
   localparam int IDEX_MEM_W       = 3;
   localparam int IDEX_WB_W        = 2;
   localparam int MEM_BRANCH_BIT   = 0;
   localparam int MEM_MEMWRITE_BIT = 1;
   localparam int MEM_MEMREAD_BIT  = 2;

endpackage

// File: rtl/hazard_stats_counter.sv
// Saturating event counter for hazard statistics.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-low reset (clears count)
//   inc_i    count one event this cycle
//   count_o  current count, sticks at all-ones
module hazard_stats_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         count_o <= '0;
      else if (inc_i && (count_o != {W{1'b1}}))
         count_o <= count_o + 1'b1;
   end

endmodule

// File: rtl/hazard_detect_unit.sv
// Load-use hazard detection and branch squash control for the ID stage.
// Compares the latched ID/EX load destination against the IF/ID source
// registers, holds PC and IF/ID while injecting bubbles for a programmable
// number of cycles, and flushes IF/ID on a taken branch unless stalling.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   idex_memread_i          ID/EX MemRead
//   idex_rtaddr_i           ID/EX rt (load destination)
//   ifid_rsaddr_i/rtaddr_i  IF/ID source fields
//   ifid_uses_rt_i          IF/ID instruction reads rt
//   branch_taken_i          ID-stage branch taken
//   pc_write_o, ifid_write_o, bubble_o, ifid_flush_o, stall_busy_o
//   stall_cnt_o, flush_cnt_o  (only with HAZARD_STATS_EN defined)
//
// Optional feature macro: HAZARD_STATS_EN (adds saturating stall/flush counters).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | normal flow; a hazard stalls this cycle (Mealy)
// ST_STALL | remaining stall cycles, counted down by cnt; haz ignored
module hazard_detect_unit
   import cpu_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  idex_memread_i,
   input  logic [REG_ADDR_W-1:0] idex_rtaddr_i,
   input  logic [REG_ADDR_W-1:0] ifid_rsaddr_i,
   input  logic [REG_ADDR_W-1:0] ifid_rtaddr_i,
   input  logic                  ifid_uses_rt_i,
   input  logic                  branch_taken_i,
   output logic                  pc_write_o,
   output logic                  ifid_write_o,
   output logic                  bubble_o,
   output logic                  ifid_flush_o,
`ifdef HAZARD_STATS_EN
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o,
`endif
   output logic                  stall_busy_o
);

   // The first stall cycle is spent in IDLE, so STALL covers the rest.
   localparam logic [2:0] STALL_LOAD = 3'(LOAD_STALL_CYCLES - 2);

   hdu_state_t state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       haz;
   logic       stall;

   assign haz = idex_memread_i && (idex_rtaddr_i != REG_ZERO) &&
                ((idex_rtaddr_i == ifid_rsaddr_i) ||
                 (ifid_uses_rt_i && (idex_rtaddr_i == ifid_rtaddr_i)));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= ST_IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            cnt_nxt = 3'd0;
            if (haz && (LOAD_STALL_CYCLES > 1)) begin
               state_nxt = ST_STALL;
               cnt_nxt   = STALL_LOAD;
            end
         end
         ST_STALL: begin
            if (cnt == 3'd0)
               state_nxt = ST_IDLE;
            else
               cnt_nxt = cnt - 3'd1;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = 3'd0;
         end
      endcase
   end

   always_comb begin
      stall        = (state == ST_STALL) || haz;
      pc_write_o   = !stall;
      ifid_write_o = !stall;
      bubble_o     = stall;
      // A stalled branch is re-resolved later with forwarded operands.
      ifid_flush_o = branch_taken_i && !stall;
      stall_busy_o = (state == ST_STALL);
   end

`ifdef HAZARD_STATS_EN
   hazard_stats_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (stall),
      .count_o (stall_cnt_o)
   );

   hazard_stats_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (ifid_flush_o),
      .count_o (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
module tb_hazard_detect_unit;

   logic clk_sys = 1'b0;
   logic rst_b   = 1'b0;

   // per-instance stimulus: a = LOAD_STALL_CYCLES=1, b = LOAD_STALL_CYCLES=3
   logic       a_mr, b_mr;
   logic [4:0] a_exrt, b_exrt, a_rs, b_rs, a_rt, b_rt;
   logic       a_uses, b_uses, a_br, b_br;
   logic       a_pw, a_iw, a_bub, a_fl, a_busy;
   logic       b_pw, b_iw, b_bub, b_fl, b_busy;
`ifdef HAZARD_STATS_EN
   logic [1:0]  a_scnt, a_fcnt;
   logic [15:0] b_scnt, b_fcnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_sys = ~clk_sys;

   hazard_detect_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(2)) dut_a (
      .clk_i(clk_sys), .rst_i(rst_b),
      .idex_memread_i(a_mr), .idex_rtaddr_i(a_exrt),
      .ifid_rsaddr_i(a_rs), .ifid_rtaddr_i(a_rt),
      .ifid_uses_rt_i(a_uses), .branch_taken_i(a_br),
      .pc_write_o(a_pw), .ifid_write_o(a_iw), .bubble_o(a_bub),
      .ifid_flush_o(a_fl),
`ifdef HAZARD_STATS_EN
      .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt),
`endif
      .stall_busy_o(a_busy)
   );

   hazard_detect_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dut_b (
      .clk_i(clk_sys), .rst_i(rst_b),
      .idex_memread_i(b_mr), .idex_rtaddr_i(b_exrt),
      .ifid_rsaddr_i(b_rs), .ifid_rtaddr_i(b_rt),
      .ifid_uses_rt_i(b_uses), .branch_taken_i(b_br),
      .pc_write_o(b_pw), .ifid_write_o(b_iw), .bubble_o(b_bub),
      .ifid_flush_o(b_fl),
`ifdef HAZARD_STATS_EN
      .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt),
`endif
      .stall_busy_o(b_busy)
   );

   typedef struct {
      string      name;
      bit         inst;      // 0 = dut_a, 1 = dut_b
      logic [4:0] exp;       // {pc_write, ifid_write, bubble, flush, busy}
   } sb_t;

   typedef struct {
      string      name;
      logic       mr;
      logic [4:0] exrt, rs, rt;
      logic       uses, br;
      logic [4:0] exp;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[$];

   task automatic drive(input bit inst, input logic mr, input logic [4:0] exrt,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses, input logic br);
      if (!inst) begin
         a_mr = mr; a_exrt = exrt; a_rs = rs; a_rt = rt; a_uses = uses; a_br = br;
      end else begin
         b_mr = mr; b_exrt = exrt; b_rs = rs; b_rt = rt; b_uses = uses; b_br = br;
      end
   endtask

   task automatic push(input string name, input bit inst, input logic [4:0] exp);
      sb_t e;
      e.name = name; e.inst = inst; e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic pop_check();
      sb_t        e;
      logic [4:0] act;
      if (sb_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_empty: actual=0 entries required>=1");
         return;
      end
      e   = sb_q.pop_front();
      act = e.inst ? {b_pw, b_iw, b_bub, b_fl, b_busy}
                   : {a_pw, a_iw, a_bub, a_fl, a_busy};
      n_cmp++;
      if (act !== e.exp) begin
         n_bad++;
         $display("FAIL %s: actual=%b required=%b (pcw,ifw,bub,flush,busy)",
                  e.name, act, e.exp);
      end
   endtask

   // drive just after the edge, check in the middle of the cycle
   task automatic step(input string name, input bit inst, input logic mr,
                       input logic [4:0] exrt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic uses, input logic br,
                       input logic [4:0] exp);
      @(posedge clk_sys); #1;
      drive(inst, mr, exrt, rs, rt, uses, br);
      push(name, inst, exp);
      @(negedge clk_sys);
      pop_check();
   endtask

   task automatic add_vec(input string name, input logic mr, input logic [4:0] exrt,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic uses, input logic br, input logic [4:0] exp);
      vec_t v;
      v.name = name; v.mr = mr; v.exrt = exrt; v.rs = rs; v.rt = rt;
      v.uses = uses; v.br = br; v.exp = exp;
      vecs.push_back(v);
   endtask

   localparam logic [4:0] RUN   = 5'b11000;
   localparam logic [4:0] HOLD  = 5'b00100;
   localparam logic [4:0] HOLDB = 5'b00101;
   localparam logic [4:0] FLUSH = 5'b11010;

   initial begin
      add_vec("idle",           1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, RUN);
      add_vec("rs_hazard",      1'b1, 5'd8,  5'd8,  5'd0,  1'b0, 1'b0, HOLD);
      add_vec("rs_release",     1'b0, 5'd8,  5'd8,  5'd0,  1'b0, 1'b0, RUN);
      add_vec("zero_reg",       1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, RUN);
      add_vec("rt_unused",      1'b1, 5'd9,  5'd3,  5'd9,  1'b0, 1'b0, RUN);
      add_vec("rt_used",        1'b1, 5'd9,  5'd3,  5'd9,  1'b1, 1'b0, HOLD);
      add_vec("addr_diff",      1'b1, 5'd9,  5'd10, 5'd11, 1'b1, 1'b0, RUN);
      add_vec("branch_vs_haz",  1'b1, 5'd4,  5'd4,  5'd0,  1'b0, 1'b1, HOLD);
      add_vec("branch_only",    1'b0, 5'd4,  5'd4,  5'd0,  1'b0, 1'b1, FLUSH);
      add_vec("reg31_hazard",   1'b1, 5'd31, 5'd31, 5'd0,  1'b0, 1'b0, HOLD);
      add_vec("branch_rt_off",  1'b1, 5'd7,  5'd1,  5'd7,  1'b0, 1'b1, FLUSH);

      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #12;
      push("reset_a", 1'b0, RUN); pop_check();
      push("reset_b", 1'b1, RUN); pop_check();
      @(negedge clk_sys); rst_b = 1'b1;

      foreach (vecs[i])
         step(vecs[i].name, 1'b0, vecs[i].mr, vecs[i].exrt, vecs[i].rs,
              vecs[i].rt, vecs[i].uses, vecs[i].br, vecs[i].exp);
      step("a_settle", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RUN);

      // three-cycle stall from a single-cycle hazard
      step("ms_c1", 1'b1, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, HOLD);
      step("ms_c2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, HOLDB);
      step("ms_c3", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, HOLDB);
      step("ms_done", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RUN);

      // branch held off for the whole stall, then flushes
      step("br_c1", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, HOLD);
      step("br_c2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, HOLDB);
      step("br_c3", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, HOLDB);
      step("br_after", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, FLUSH);
      step("br_idle", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RUN);

      // reset asserted in the second stall cycle
      step("rs_c1", 1'b1, 1'b1, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0, HOLD);
      @(posedge clk_sys); #1;
      drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      push("rs_c2_busy", 1'b1, HOLDB); pop_check();
      #1 rst_b = 1'b0;
      #1 push("rs_async", 1'b1, RUN); pop_check();
      @(negedge clk_sys); rst_b = 1'b1;
      step("rs_no_resume", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RUN);
      step("rs_no_resume2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, RUN);

`ifdef HAZARD_STATS_EN
      @(negedge clk_sys); rst_b = 1'b0;
      #1;
      n_cmp++;
      if (a_scnt !== 2'd0 || a_fcnt !== 2'd0) begin
         n_bad++;
         $display("FAIL stats_reset: actual=%0d/%0d required=0/0", a_scnt, a_fcnt);
      end
      @(negedge clk_sys); rst_b = 1'b1;
      for (int k = 0; k < 5; k++)
         step("stats_stall", 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, HOLD);
      step("stats_flush", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, FLUSH);
      @(posedge clk_sys); #1;
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      n_cmp++;
      if (a_scnt !== 2'd3) begin
         n_bad++;
         $display("FAIL stats_stall_sat: actual=%0d required=3", a_scnt);
      end
      n_cmp++;
      if (a_fcnt !== 2'd1) begin
         n_bad++;
         $display("FAIL stats_flush: actual=%0d required=1", a_fcnt);
      end
`endif

      if (sb_q.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_leftover: actual=%0d required=0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
